// File: rtl/responder_link.sv
// Challenge/response link: parses "CHAL:<32 hex>\n", hands the nonce to a cipher
// engine, streams back "RESP:<32 hex>\n", and can also emit single Y/N command bytes.
module responder_link #(
  parameter int CHAR_TIMEOUT = 60_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_data_valid,
  output logic [7:0]   tx_data,
  output logic         tx_data_valid,
  input  logic         tx_busy,
  output logic         cipher_start,
  output logic [127:0] cipher_nonce,
  input  logic [127:0] cipher_result,
  input  logic         cipher_valid,
  input  logic         cmd_req,
  input  logic         cmd_yes,
  output logic         busy,
  output logic         resp_done,
  output logic [7:0]   err_count
);

  localparam int TW = (CHAR_TIMEOUT > 1) ? $clog2(CHAR_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CHAR_TIMEOUT - 1);
  localparam logic [5:0] RESP_LEN = 6'd38;

  typedef enum logic [2:0] {HUNT, HEX, EOL, START, WAIT, SEND} state_t;

  state_t        state, state_next;
  logic [2:0]    match_idx, match_next;
  logic [4:0]    hex_cnt;
  logic [TW-1:0] timer;
  logic [127:0]  result;
  logic [5:0]    send_idx;
  logic          outstanding, risen, pend, pend_yes;
  logic          tx_done, can_issue, parsing, timeout;
  logic          hex_ok;
  logic [3:0]    hex_nib;
  logic          err_inc, hex_clear, shift_nib, latch_result;
  logic          send_issue, cmd_issue, done_now;

  function automatic logic [7:0] prefix_char(input logic [2:0] idx);
    case (idx)
      3'd0:    prefix_char = 8'h43;
      3'd1:    prefix_char = 8'h48;
      3'd2:    prefix_char = 8'h41;
      3'd3:    prefix_char = 8'h4C;
      default: prefix_char = 8'h3A;
    endcase
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  // Response layout: "RESP:" (0..4), 32 nibbles MSB first (5..36), newline (37).
  function automatic logic [7:0] resp_byte(input logic [5:0] idx, input logic [127:0] val);
    logic [6:0] lo;
    lo = 7'((7'd36 - {1'b0, idx}) << 2);
    case (idx)
      6'd0:    resp_byte = 8'h52;
      6'd1:    resp_byte = 8'h45;
      6'd2:    resp_byte = 8'h53;
      6'd3:    resp_byte = 8'h50;
      6'd4:    resp_byte = 8'h3A;
      6'd37:   resp_byte = 8'h0A;
      default: resp_byte = hex_ascii(val[lo +: 4]);
    endcase
  endfunction

  always_comb begin
    hex_ok  = 1'b0;
    hex_nib = 4'd0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_nib = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      hex_ok  = 1'b1;
      hex_nib = rx_data[3:0] + 4'd9;
    end
  end

  // A byte is outstanding until tx_busy has been seen high and then drops.
  assign tx_done   = outstanding & risen & ~tx_busy;
  assign can_issue = ~outstanding & ~tx_busy;
  assign parsing   = (state == HEX) || (state == EOL);
  assign timeout   = parsing & ~rx_data_valid & (timer == T_LAST);

  assign cipher_start = (state == START);
  assign busy         = (state != HUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    match_next   = match_idx;
    err_inc      = 1'b0;
    hex_clear    = 1'b0;
    shift_nib    = 1'b0;
    latch_result = 1'b0;
    send_issue   = 1'b0;
    cmd_issue    = 1'b0;
    done_now     = 1'b0;
    case (state)
      HUNT: begin
        // A same-cycle cmd_req defers the send so the newest request wins.
        cmd_issue = pend & ~cmd_req & (match_idx == 3'd0) & can_issue;
        if (rx_data_valid) begin
          if (rx_data == prefix_char(match_idx)) begin
            if (match_idx == 3'd4) begin
              match_next = 3'd0;
              hex_clear  = 1'b1;
              state_next = HEX;
            end else begin
              match_next = match_idx + 3'd1;
            end
          end else begin
            match_next = (rx_data == 8'h43) ? 3'd1 : 3'd0;
          end
        end
      end
      HEX: begin
        if (timeout) begin
          err_inc    = 1'b1;
          state_next = HUNT;
        end else if (rx_data_valid) begin
          if (hex_ok) begin
            shift_nib = 1'b1;
            if (hex_cnt == 5'd31) state_next = EOL;
          end else begin
            err_inc    = 1'b1;
            state_next = HUNT;
          end
        end
      end
      EOL: begin
        if (timeout) begin
          err_inc    = 1'b1;
          state_next = HUNT;
        end else if (rx_data_valid) begin
          if (rx_data == 8'h0A) begin
            state_next = START;
          end else begin
            err_inc    = 1'b1;
            state_next = HUNT;
          end
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (cipher_valid) begin
          latch_result = 1'b1;
          state_next   = SEND;
        end
      end
      SEND: begin
        if (send_idx == RESP_LEN) begin
          if (tx_done) begin
            done_now   = 1'b1;
            state_next = HUNT;
          end
        end else if (can_issue) begin
          send_issue = 1'b1;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_idx     <= 3'd0;
      hex_cnt       <= 5'd0;
      timer         <= '0;
      cipher_nonce  <= '0;
      result        <= '0;
      send_idx      <= 6'd0;
      tx_data       <= 8'd0;
      tx_data_valid <= 1'b0;
      outstanding   <= 1'b0;
      risen         <= 1'b0;
      pend          <= 1'b0;
      pend_yes      <= 1'b0;
      resp_done     <= 1'b0;
      err_count     <= 8'd0;
    end else begin
      match_idx     <= match_next;
      resp_done     <= done_now;
      tx_data_valid <= send_issue | cmd_issue;

      if (hex_clear)      hex_cnt <= 5'd0;
      else if (shift_nib) hex_cnt <= hex_cnt + 5'd1;

      if (shift_nib) cipher_nonce <= {cipher_nonce[123:0], hex_nib};

      if (parsing && !rx_data_valid && !timeout) timer <= timer + TW'(1);
      else                                       timer <= '0;

      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;

      if (latch_result) begin
        result   <= cipher_result;
        send_idx <= 6'd0;
      end else if (send_issue) begin
        send_idx <= send_idx + 6'd1;
      end

      // tx_data only changes when a new byte is issued, so it holds while outstanding.
      if (send_issue)     tx_data <= resp_byte(send_idx, result);
      else if (cmd_issue) tx_data <= pend_yes ? 8'h59 : 8'h4E;

      if (send_issue || cmd_issue) begin
        outstanding <= 1'b1;
        risen       <= 1'b0;
      end else if (outstanding) begin
        if (tx_busy) risen <= 1'b1;
        if (tx_done) outstanding <= 1'b0;
      end

      if (cmd_req) begin
        pend     <= 1'b1;
        pend_yes <= cmd_yes;
      end else if (cmd_issue) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_responder_link.sv
// Scoreboarded bench for responder_link: stimulus pushes expected TX bytes, nonces
// and cipher results into queues; monitor, engine and transmitter processes check them.
module tb_responder_link;

  localparam int CHAR_TIMEOUT = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_data_valid;
  logic [7:0]   tx_data;
  logic         tx_data_valid;
  logic         tx_busy;
  logic         cipher_start;
  logic [127:0] cipher_nonce;
  logic [127:0] cipher_result;
  logic         cipher_valid;
  logic         cmd_req;
  logic         cmd_yes;
  logic         busy;
  logic         resp_done;
  logic [7:0]   err_count;

  responder_link #(.CHAR_TIMEOUT(CHAR_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_busy(tx_busy),
    .cipher_start(cipher_start), .cipher_nonce(cipher_nonce),
    .cipher_result(cipher_result), .cipher_valid(cipher_valid),
    .cmd_req(cmd_req), .cmd_yes(cmd_yes),
    .busy(busy), .resp_done(resp_done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]   exp_q[$];
  logic [127:0] result_q[$];
  logic [127:0] nonce_q[$];
  int           delay_q[$];
  logic [7:0]   stim_q[$];
  int tx_count = 0, done_count = 0, start_count = 0;
  int exp_done = 0, exp_starts = 0, model_err = 0;
  string hexdig = "0123456789ABCDEF";
  string hexlo  = "abcdef";
  string junk   = "CHAX1 ";
  string badc   = "Gz-Q";

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic addStr(input string s);
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endtask

  task automatic addHex(input int count, inout logic [127:0] val);
    for (int i = 0; i < count; i++) begin
      logic [3:0] nib;
      nib = 4'($urandom_range(0, 15));
      val = {val[123:0], nib};
      if (nib >= 4'd10 && $urandom_range(0, 1) == 1) stim_q.push_back(hexlo[int'(nib) - 10]);
      else stim_q.push_back(hexdig[nib]);
    end
  endtask

  task automatic applyStimulus();
    while (stim_q.size() > 0) begin
      @(negedge clk);
      rx_data       = stim_q.pop_front();
      rx_data_valid = 1'b1;
      @(negedge clk);
      rx_data_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Reference response: "RESP:" + uppercase hex of the result MSB first + newline.
  task automatic queueChallenge(input logic [127:0] r, input int delay, input logic [127:0] nonce);
    string pre = "RESP:";
    result_q.push_back(r);
    delay_q.push_back(delay);
    nonce_q.push_back(nonce);
    exp_starts++;
    exp_done++;
    for (int i = 0; i < 5; i++) exp_q.push_back(pre[i]);
    for (int i = 0; i < 32; i++) exp_q.push_back(hexdig[r[127 - 4*i -: 4]]);
    exp_q.push_back(8'h0A);
  endtask

  task automatic waitDone();
    int budget = 5000;
    while (done_count < exp_done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("resp_done count", 128'(done_count), 128'(exp_done));
  endtask

  task automatic pulseCmd(input logic yes);
    @(negedge clk);
    cmd_req = 1'b1;
    cmd_yes = yes;
    @(negedge clk);
    cmd_req = 1'b0;
  endtask

  function automatic logic [127:0] randWide();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (cipher_start) start_count++;
      if (resp_done) done_count++;
      if (tx_data_valid) begin
        tx_count++;
        if (exp_q.size() == 0) checkOutput("unexpected tx byte", 128'(tx_data), 128'h1FF);
        else checkOutput("tx byte", 128'(tx_data), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin : engine
    logic [127:0] r, n;
    int d;
    cipher_valid  = 1'b0;
    cipher_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (cipher_start && result_q.size() > 0) begin
        r = result_q.pop_front();
        d = delay_q.pop_front();
        n = nonce_q.pop_front();
        checkOutput("cipher_nonce at start", cipher_nonce, n);
        repeat (d) @(posedge clk);
        #1;
        checkOutput("cipher_nonce stable", cipher_nonce, n);
        cipher_valid  = 1'b1;
        cipher_result = r;
        @(posedge clk);
        #1;
        cipher_valid  = 1'b0;
        cipher_result = randWide();
      end
    end
  end

  initial begin : tx_model
    logic [7:0] held;
    int n;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_data_valid && !rst) begin
        held    = tx_data;
        tx_busy = 1'b1;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n && !rst; i++) @(posedge clk);
        #1;
        if (!rst) checkOutput("tx_data hold", 128'(tx_data), 128'(held));
        tx_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [127:0] n, r;
    int base, budget, kind;
    rst = 1'b1; rx_data = 8'd0; rx_data_valid = 1'b0; cmd_req = 1'b0; cmd_yes = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset tx_data_valid", 128'(tx_data_valid), 128'd0);
    checkOutput("reset tx_data", 128'(tx_data), 128'd0);
    checkOutput("reset cipher_start", 128'(cipher_start), 128'd0);
    checkOutput("reset cipher_nonce", cipher_nonce, 128'd0);
    checkOutput("reset busy", 128'(busy), 128'd0);
    checkOutput("reset resp_done", 128'(resp_done), 128'd0);
    checkOutput("reset err_count", 128'(err_count), 128'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] directed challenge with fixed engine result");
    queueChallenge(128'hDEADBEEF00112233445566778899AABB, 20, 128'h0123456789ABCDEF0123456789ABCDEF);
    addStr("CHAL:0123456789ABCDEF0123456789abcdef\n");
    applyStimulus();
    waitDone();
    checkOutput("single cipher_start", 128'(start_count), 128'd1);
    checkOutput("nonce after response", cipher_nonce, 128'h0123456789ABCDEF0123456789ABCDEF);

    $display("[TB] doubled C before prefix");
    n = '0;
    addStr("CCHAL:");
    addHex(32, n);
    addStr("\n");
    queueChallenge(randWide(), $urandom_range(1, 30), n);
    applyStimulus();
    waitDone();
    checkOutput("err_count after CCHAL", 128'(err_count), 128'(model_err));

    $display("[TB] bad hex character");
    addStr("CHAL:01G");
    applyStimulus();
    repeat (3) @(negedge clk);
    model_err++;
    checkOutput("err_count after bad hex", 128'(err_count), 128'(model_err));
    checkOutput("busy after bad hex", 128'(busy), 128'd0);
    checkOutput("no start on bad hex", 128'(start_count), 128'(exp_starts));
    n = '0;
    addStr("CHAL:");
    addHex(32, n);
    addStr("\n");
    queueChallenge(randWide(), $urandom_range(1, 30), n);
    applyStimulus();
    waitDone();

    $display("[TB] idle timeout mid-challenge");
    n = '0;
    addStr("CHAL:");
    addHex(10, n);
    applyStimulus();
    repeat (CHAR_TIMEOUT / 2) @(negedge clk);
    checkOutput("busy before timeout", 128'(busy), 128'd1);
    checkOutput("err_count before timeout", 128'(err_count), 128'(model_err));
    repeat (CHAR_TIMEOUT) @(negedge clk);
    model_err++;
    checkOutput("err_count after timeout", 128'(err_count), 128'(model_err));
    checkOutput("busy after timeout", 128'(busy), 128'd0);

    $display("[TB] overwritten command request");
    base = tx_count;
    exp_q.push_back(8'h4E);
    @(negedge clk);
    cmd_req = 1'b1; cmd_yes = 1'b1;
    @(negedge clk);
    cmd_yes = 1'b0;
    @(negedge clk);
    cmd_req = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("command byte count", 128'(tx_count - base), 128'd1);

    $display("[TB] reset during response");
    n = '0;
    addStr("CHAL:");
    addHex(32, n);
    addStr("\n");
    queueChallenge(randWide(), $urandom_range(1, 30), n);
    base = tx_count;
    applyStimulus();
    budget = 3000;
    while (tx_count < base + 12 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("bytes before reset", 128'(tx_count - base), 128'd12);
    rst = 1'b1;
    exp_q.delete();
    exp_done--;
    model_err = 0;
    @(negedge clk);
    checkOutput("mid-send reset tx_data_valid", 128'(tx_data_valid), 128'd0);
    checkOutput("mid-send reset tx_data", 128'(tx_data), 128'd0);
    checkOutput("mid-send reset busy", 128'(busy), 128'd0);
    checkOutput("mid-send reset err_count", 128'(err_count), 128'd0);
    checkOutput("mid-send reset cipher_nonce", cipher_nonce, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = tx_count;
    repeat (100) @(negedge clk);
    checkOutput("no bytes after abort", 128'(tx_count - base), 128'd0);
    n = '0;
    addStr("CHAL:");
    addHex(32, n);
    addStr("\n");
    queueChallenge(randWide(), $urandom_range(1, 30), n);
    base = tx_count;
    applyStimulus();
    waitDone();
    checkOutput("full response after reset", 128'(tx_count - base), 128'd38);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 16; it++) begin
      for (int j = $urandom_range(0, 3); j > 0; j--) stim_q.push_back(junk[$urandom_range(0, 5)]);
      kind = $urandom_range(0, 3);
      n = '0;
      addStr("CHAL:");
      if (kind == 2) begin
        base = $urandom_range(0, 31);
        addHex(base, n);
        stim_q.push_back(badc[$urandom_range(0, 3)]);
        addHex(31 - base, n);
        applyStimulus();
        repeat (3) @(negedge clk);
        if (model_err < 255) model_err++;
        checkOutput("err_count random bad hex", 128'(err_count), 128'(model_err));
        checkOutput("busy random bad hex", 128'(busy), 128'd0);
      end else if (kind == 3) begin
        addHex(32, n);
        addStr("X");
        applyStimulus();
        repeat (3) @(negedge clk);
        if (model_err < 255) model_err++;
        checkOutput("err_count random bad eol", 128'(err_count), 128'(model_err));
        checkOutput("busy random bad eol", 128'(busy), 128'd0);
      end else begin
        addHex(32, n);
        addStr("\n");
        r = randWide();
        queueChallenge(r, $urandom_range(1, 30), n);
        applyStimulus();
        waitDone();
        checkOutput("err_count random valid", 128'(err_count), 128'(model_err));
        if ($urandom_range(0, 1) == 1) begin
          kind = $urandom_range(0, 1);
          exp_q.push_back(kind == 1 ? 8'h59 : 8'h4E);
          pulseCmd(kind == 1);
        end
      end
    end

    repeat (60) @(negedge clk);
    checkOutput("total cipher_start", 128'(start_count), 128'(exp_starts));
    checkOutput("leftover expected bytes", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/responder_link.md
RESPONDER_LINK -- requirements
Module: responder_link

Interface
REQ-001 Parameter CHAR_TIMEOUT, default 60_000_000, is the idle-cycle limit between received bytes while a challenge is being parsed.
REQ-002 Port clk, input, 1, is the single clock; all logic is rising-edge.
REQ-003 Port rst, input, 1, is the reset: asynchronous and active-high.
REQ-004 Port rx_data, input, 8, is the received byte.
REQ-005 Port rx_data_valid, input, 1, is a one-cycle strobe marking rx_data valid.
REQ-006 Port tx_data, output, 8, is the byte to transmit.
REQ-007 Port tx_data_valid, output, 1, is a one-cycle transmit strobe.
REQ-008 Port tx_busy, input, 1, is high while the transmitter is shifting; it rises within 2 cycles of tx_data_valid.
REQ-009 Port cipher_start, output, 1, is a one-cycle pulse that requests a response computation.
REQ-010 Port cipher_nonce, output, 128, is the parsed challenge; it stays stable from cipher_start until cipher_valid.
REQ-011 Ports cipher_result, input, 128, and cipher_valid, input, 1, carry the engine output; cipher_result is valid while cipher_valid is high.
REQ-012 Ports cmd_req, input, 1, and cmd_yes, input, 1, form the command request: 1 requests 'Y', 0 requests 'N'.
REQ-013 Port busy, output, 1, is high whenever the state is not HUNT.
REQ-014 Port resp_done, output, 1, pulses for one cycle after the final '\n' of a response is issued.
REQ-015 Port err_count, output, 8, counts malformed challenges and saturates at 255.

Function
REQ-016 The states are HUNT, HEX, EOL, START, WAIT, SEND.
REQ-017 HUNT matches the prefix "CHAL:" (43 48 41 4C 3A) with a 0..4 match index; after the fifth byte the block clears the hex count and goes to HEX.
REQ-018 On a prefix mismatch in HUNT, the match index becomes 1 if the byte is 'C' and 0 otherwise; err_count is not changed.
REQ-019 HEX accepts '0'-'9', 'A'-'F' and 'a'-'f', and shifts each nibble into cipher_nonce from the LSB end, so the first character becomes bits [127:124]; after 32 characters the block goes to EOL.
REQ-020 A non-hex byte in HEX increments err_count and returns the block to HUNT with the match index at 0.
REQ-021 In EOL, 0x0A goes to START; any other byte increments err_count and returns to HUNT.
REQ-022 In HEX or EOL, if CHAR_TIMEOUT cycles pass with no rx_data_valid, err_count increments and the block returns to HUNT; the timer resets on every received byte.
REQ-023 START asserts cipher_start for exactly one cycle, then goes to WAIT.
REQ-024 WAIT latches cipher_result on the first cycle cipher_valid is high, then goes to SEND; it has no timeout.
REQ-025 SEND transmits 38 bytes: "RESP:", then 32 uppercase hex characters of the latched result MSB nibble first, then 0x0A.
REQ-026 Send handshake: issue a byte only when tx_busy=0 and no byte is outstanding; a byte is outstanding from its tx_data_valid until tx_busy falls after having risen.
REQ-027 tx_data holds its value from tx_data_valid until the outstanding byte completes.
REQ-028 resp_done pulses on the cycle the final 0x0A completes, and the block returns to HUNT on that same cycle.
REQ-029 Bytes arriving in START, WAIT or SEND are dropped without changing err_count.
REQ-030 cmd_req latches a one-deep pending command; a new cmd_req while one is pending overwrites cmd_yes.
REQ-031 A pending command is sent as 'Y' (0x59) or 'N' (0x4E) only in HUNT with the match index at 0 and no byte outstanding; the pending flag clears when the byte is issued.
REQ-032 If cmd_req and a send opportunity occur in the same cycle, the new value is latched and sent on a later cycle.
REQ-033 If a challenge prefix begins while a command byte is outstanding, parsing continues normally; SEND waits for the outstanding byte to complete.
REQ-034 cipher_valid seen outside WAIT is ignored.

Reset
REQ-035 While rst is high: state=HUNT, match index=0, tx_data_valid=0, tx_data=0, cipher_start=0, cipher_nonce=0, busy=0, resp_done=0, err_count=0, pending command cleared, outstanding flag cleared, timer=0.
REQ-036 A reset asserted mid-parse or mid-send aborts the transfer immediately; after release, no further bytes of the aborted response are emitted.

Verification
REQ-037 Send "CHAL:0123456789ABCDEF0123456789abcdef\n", with the engine model returning 128'hDEADBEEF00112233445566778899AABB 20 cycles after start -> exactly one cipher_start, cipher_nonce=128'h0123456789ABCDEF0123456789ABCDEF, TX="RESP:DEADBEEF00112233445566778899AABB\n", one resp_done pulse.
REQ-038 Send "CHAL:01G…" -> err_count=1, no cipher_start; a following valid challenge is answered correctly.
REQ-039 Send "CCHAL:" followed by 32 hex characters and '\n' -> the challenge is accepted and err_count=0.
REQ-040 Send "CHAL:" plus 10 hex characters, then stay idle for CHAR_TIMEOUT cycles (set to 1000 in the bench) -> err_count=1 and busy=0.
REQ-041 Pulse cmd_req with cmd_yes=1, then with cmd_yes=0, before the first byte is issued -> exactly one byte 0x4E is transmitted.
REQ-042 Assert rst after the 12th response byte -> TX goes idle and all outputs take their reset values; a new challenge after release gets a complete 38-byte response.
